// File: rtl/decode_fwd_if.sv
// decode_fwd_if: fetch-side, register-file, bypass and EX-side signals of the decode stage
interface decode_fwd_if #(parameter int XLEN = 32, parameter int NFWD = 3);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     ins_in;
  logic [XLEN-1:0] pc_in;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rso1;
  logic [XLEN-1:0] rso2;
  logic [NFWD-1:0] fwd_en;
  logic [5*NFWD-1:0] fwd_rd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic            ex_ld_valid;
  logic [4:0]      ex_ld_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     ins_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [15:0]     stall_cnt;
  modport master (
    output in_valid, ins_in, pc_in, rso1, rso2, fwd_en, fwd_rd, fwd_data,
           ex_ld_valid, ex_ld_rd, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, ins_out, pc_out, op1, op2, stall_cnt
  );
  modport slave (
    input  in_valid, ins_in, pc_in, rso1, rso2, fwd_en, fwd_rd, fwd_data,
           ex_ld_valid, ex_ld_rd, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, ins_out, pc_out, op1, op2, stall_cnt
  );
endinterface

// File: rtl/decode_fwd_stage.sv
// decode_fwd_stage: operand bypass resolve, load-use interlock and registered decode output
module decode_fwd_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input logic         clk,
  input logic         rst,
  decode_fwd_if.slave bus
);
  logic [XLEN-1:0] op1_r, op2_r;
  logic            hazard, capture;
  // Scan oldest to youngest so the youngest matching source wins; x0 always reads zero.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]           a,
    input logic [XLEN-1:0]      rso,
    input logic [NFWD-1:0]      en,
    input logic [5*NFWD-1:0]    rd,
    input logic [XLEN*NFWD-1:0] data
  );
    logic [XLEN-1:0] r;
    r = rso;
    for (int i = NFWD - 1; i >= 0; i--)
      if (en[i] && rd[5*i +: 5] == a) r = data[XLEN*i +: XLEN];
    return a == 5'd0 ? '0 : r;
  endfunction
  assign bus.rs1_addr = bus.ins_in[19:15];
  assign bus.rs2_addr = bus.ins_in[24:20];
  always_comb begin
    op1_r = resolve(bus.rs1_addr, bus.rso1, bus.fwd_en, bus.fwd_rd, bus.fwd_data);
    op2_r = resolve(bus.rs2_addr, bus.rso2, bus.fwd_en, bus.fwd_rd, bus.fwd_data);
  end
  assign hazard = bus.in_valid & bus.ex_ld_valid & (bus.ex_ld_rd != 5'd0) &
                  (bus.ex_ld_rd == bus.rs1_addr | bus.ex_ld_rd == bus.rs2_addr);
  assign bus.in_ready = (!bus.out_valid | bus.out_ready) & !hazard & !bus.flush;
  assign capture = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.ins_out   <= '0;
      bus.pc_out    <= '0;
      bus.op1       <= '0;
      bus.op2       <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (hazard && bus.stall_cnt != 16'hFFFF) bus.stall_cnt <= bus.stall_cnt + 16'd1;
      bus.out_valid <= bus.flush ? 1'b0 : capture ? 1'b1 : bus.out_ready ? 1'b0 : bus.out_valid;
      if (capture) begin
        bus.ins_out <= bus.ins_in;
        bus.pc_out  <= bus.pc_in;
        bus.op1     <= op1_r;
        bus.op2     <= op2_r;
      end
    end
  end
endmodule

// File: tb/tb_decode_fwd_stage.sv
// tb_decode_fwd_stage: table-driven bypass vectors plus hand sequences for stalls, backpressure, flush and reset
module tb_decode_fwd_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  decode_fwd_if #(.XLEN(32), .NFWD(3)) bus ();
  decode_fwd_stage #(.XLEN(32), .NFWD(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  r1, r2;
    logic [31:0] rso1, rso2;
    logic [2:0]  en;
    logic [14:0] rd;
    logic [95:0] data;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t v[7];
  function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] t);
    return {t, r2, r1, 3'b000, 5'd1, 7'h33};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0] = '{5'd5, 5'd6, 32'hAAAA, 32'hBBBB, 3'b111, {5'd5, 5'd5, 5'd5}, {32'h33, 32'h22, 32'h11}, 32'h11, 32'hBBBB};
    v[1] = '{5'd0, 5'd0, 32'hFFFF, 32'hFFFF, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hDEAD}, 32'h0, 32'h0};
    v[2] = '{5'd3, 5'd4, 32'h100, 32'h200, 3'b000, {5'd3, 5'd4, 5'd3}, {32'h1, 32'h2, 32'h3}, 32'h100, 32'h200};
    v[3] = '{5'd8, 5'd9, 32'h500, 32'h600, 3'b010, {5'd8, 5'd9, 5'd8}, {32'h333, 32'h222, 32'h111}, 32'h500, 32'h222};
    v[4] = '{5'd10, 5'd11, 32'h700, 32'h800, 3'b110, {5'd10, 5'd10, 5'd11}, {32'h333, 32'h222, 32'h111}, 32'h222, 32'h800};
    v[5] = '{5'd12, 5'd0, 32'h900, 32'h901, 3'b111, {5'd12, 5'd0, 5'd0}, {32'h444, 32'h555, 32'h666}, 32'h444, 32'h0};
    v[6] = '{5'd31, 5'd1, 32'hA00, 32'hB00, 3'b100, {5'd1, 5'd31, 5'd31}, {32'h777, 32'h888, 32'h999}, 32'hA00, 32'h777};
    bus.in_valid = 1'b0; bus.ins_in = '0; bus.pc_in = '0; bus.rso1 = '0; bus.rso2 = '0;
    bus.fwd_en = '0; bus.fwd_rd = '0; bus.fwd_data = '0; bus.ex_ld_valid = 1'b0;
    bus.ex_ld_rd = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_op1", bus.op1, 32'd0);
    chk("reset_stall_cnt", {16'b0, bus.stall_cnt}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.ins_in = mk(v[i].r1, v[i].r2, 7'(i));
      bus.pc_in = 32'h1000 + 32'(4 * i);
      bus.rso1 = v[i].rso1; bus.rso2 = v[i].rso2;
      bus.fwd_en = v[i].en; bus.fwd_rd = v[i].rd; bus.fwd_data = v[i].data;
      #1;
      chk("vec_rs1_addr", {27'b0, bus.rs1_addr}, {27'b0, v[i].r1});
      chk("vec_rs2_addr", {27'b0, bus.rs2_addr}, {27'b0, v[i].r2});
      chk("vec_in_ready", {31'b0, bus.in_ready}, 32'd1);
      tick();
      chk("vec_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("vec_op1", bus.op1, v[i].e1);
      chk("vec_op2", bus.op2, v[i].e2);
      chk("vec_ins_out", bus.ins_out, mk(v[i].r1, v[i].r2, 7'(i)));
      chk("vec_pc_out", bus.pc_out, 32'h1000 + 32'(4 * i));
    end
    // load-use interlock on rs2 for two cycles
    bus.ins_in = mk(5'd2, 5'd7, 7'h10); bus.pc_in = 32'h2000;
    bus.fwd_en = '0; bus.rso1 = 32'h1234; bus.rso2 = 32'h5678;
    bus.ex_ld_valid = 1'b1; bus.ex_ld_rd = 5'd7;
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk("lu_in_ready", {31'b0, bus.in_ready}, 32'd0);
      tick();
      chk("lu_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("lu_stall_cnt", {16'b0, bus.stall_cnt}, 32'(k));
    end
    bus.ex_ld_valid = 1'b0;
    #1;
    chk("lu_release_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("lu_cap_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("lu_cap_op1", bus.op1, 32'h1234);
    chk("lu_cap_op2", bus.op2, 32'h5678);
    chk("lu_cap_stall", {16'b0, bus.stall_cnt}, 32'd2);
    // backpressure with changing bypass data
    bus.out_ready = 1'b0;
    bus.ins_in = mk(5'd5, 5'd6, 7'h11); bus.pc_in = 32'h3000;
    bus.fwd_en = 3'b111; bus.fwd_rd = {5'd5, 5'd5, 5'd5};
    for (int k = 0; k < 4; k++) begin
      bus.fwd_data = {32'(k + 100), 32'(k + 200), 32'(k + 300)};
      #1;
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      tick();
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_op1", bus.op1, 32'h1234);
      chk("bp_op2", bus.op2, 32'h5678);
      chk("bp_ins_out", bus.ins_out, mk(5'd2, 5'd7, 7'h10));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_cap_op1", bus.op1, 32'd303);
    chk("bp_cap_op2", bus.op2, 32'h5678);
    chk("bp_cap_pc", bus.pc_out, 32'h3000);
    // drain with no input: valid drops, data holds, no stall counting
    bus.in_valid = 1'b0; bus.ex_ld_valid = 1'b1; bus.ex_ld_rd = 5'd5;
    tick();
    chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("drain_ins_hold", bus.ins_out, mk(5'd5, 5'd6, 7'h11));
    chk("idle_stall_cnt", {16'b0, bus.stall_cnt}, 32'd2);
    bus.ex_ld_valid = 1'b0;
    // flush overrides a would-be capture
    bus.in_valid = 1'b1; bus.ins_in = mk(5'd3, 5'd4, 7'h12); bus.flush = 1'b1;
    tick();
    chk("flush_vs_capture", {31'b0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;
    tick();
    chk("post_flush_capture", {31'b0, bus.out_valid}, 32'd1);
    // flush overrides a hold under backpressure
    bus.out_ready = 1'b0; bus.flush = 1'b1;
    tick();
    chk("flush_vs_hold", {31'b0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.ins_in = mk(5'd1, 5'd7, 7'h13);
    tick();
    // hold a valid output under a long hazard until the counter saturates
    bus.out_ready = 1'b0; bus.ex_ld_valid = 1'b1; bus.ex_ld_rd = 5'd7;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall_cnt", {16'b0, bus.stall_cnt}, 32'hFFFF);
    chk("sat_out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("arst_stall_cnt", {16'b0, bus.stall_cnt}, 32'd0);
    chk("arst_ins_out", bus.ins_out, 32'd0);
    chk("arst_pc_out", bus.pc_out, 32'd0);
    chk("arst_op1", bus.op1, 32'd0);
    chk("arst_op2", bus.op2, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.ex_ld_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ins_in = mk(5'd9, 5'd10, 7'h14); bus.pc_in = 32'h4000;
    bus.fwd_en = '0; bus.rso1 = 32'hC1; bus.rso2 = 32'hC2;
    tick();
    chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("post_rst_ins", bus.ins_out, mk(5'd9, 5'd10, 7'h14));
    chk("post_rst_op2", bus.op2, 32'hC2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_fwd_stage.md
DECODE_FWD_STAGE -- requirements
Module: decode_fwd_stage

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width.
REQ-002 Parameter NFWD, default 3: number of forwarding sources; index 0 is the youngest (EX), NFWD-1 the oldest (WB).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  upstream (fetch) instruction valid.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 ins_in  in  32  instruction word.
REQ-008 pc_in  in  XLEN  instruction PC.
REQ-009 rs1_addr, rs2_addr  out  5 each  register-file read addresses, ins_in[19:15] and ins_in[24:20], combinational.
REQ-010 rso1, rso2  in  XLEN each  register-file read data, same cycle.
REQ-011 fwd_en  in  NFWD  per-source write-enable.
REQ-012 fwd_rd  in  5*NFWD  per-source destination register; source i at [5i+4:5i].
REQ-013 fwd_data  in  XLEN*NFWD  per-source result; source i at [XLEN*i+XLEN-1:XLEN*i].
REQ-014 ex_ld_valid, ex_ld_rd  in  1, 5  EX holds a load whose data is not yet available, and its destination.
REQ-015 flush  in  1  kill the instruction in this stage, synchronous.
REQ-016 out_valid  out  1  registered outputs hold a valid instruction.
REQ-017 out_ready  in  1  downstream (EX) accepts.
REQ-018 ins_out, pc_out, op1, op2  out  32, XLEN, XLEN, XLEN  registered instruction, PC and resolved operands.
REQ-019 stall_cnt  out  16  saturating load-use stall counter.

Function
REQ-020 Operand resolve, combinational: if rsN_addr == 0 the operand is 0; else the lowest index i with fwd_en[i]=1 and fwd_rd[i]==rsN_addr supplies fwd_data[i]; else rsoN.
REQ-021 A source with fwd_en[i]=1 and fwd_rd[i]=0 never forwards.
REQ-022 hazard = in_valid & ex_ld_valid & ex_ld_rd!=0 & (ex_ld_rd==rs1_addr | ex_ld_rd==rs2_addr); both fields are treated as used for every opcode.
REQ-023 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-024 Capture: when in_valid & in_ready, on the next clk edge ins_out<=ins_in, pc_out<=pc_in, op1/op2<=resolved operands, out_valid<=1; latency is 1 cycle.
REQ-025 When out_valid & out_ready and no capture occurs, out_valid<=0 and the data registers hold.
REQ-026 When out_valid & !out_ready, all output registers hold unchanged, including when forwarding inputs change.
REQ-027 During a hazard no capture occurs; if downstream consumes, out_valid<=0, which inserts one bubble per hazard cycle.
REQ-028 flush=1 forces out_valid<=0 at the next edge, overriding capture and hold; the data registers are don't-care.
REQ-029 stall_cnt increments by 1 on each clk edge where hazard=1; it saturates at 16'hFFFF and does not wrap.
REQ-030 When in_valid=0, no capture occurs and the stall counter does not increment.

Reset
REQ-031 While rst=1, asynchronously: out_valid=0, ins_out=0, pc_out=0, op1=0, op2=0, stall_cnt=0.
REQ-032 After rst deasserts, the first capture may occur at the first rising edge; rst asserted mid-transfer discards the held instruction.

Verification
REQ-033 Bypass priority: ins_in rs1=5, fwd_en=3'b111, fwd_rd={5,5,5}, data {WB=0x33, MEM=0x22, EX=0x11} -> op1=0x11 one cycle later.
REQ-034 x0: rs1=0, rs2=0, fwd_en[0]=1, fwd_rd[0]=0, data=0xDEAD, rso1=rso2=0xFFFF -> op1=op2=0.
REQ-035 Load-use: ex_ld_valid=1, ex_ld_rd=7, rs2=7 for 2 cycles -> in_ready=0 for 2 cycles, out_valid=0 after consume, stall_cnt=2; then capture.
REQ-036 Backpressure: out_valid=1, out_ready=0 for 4 cycles while fwd_data changes -> op1, op2, ins_out stable, in_ready=0.
REQ-037 Flush versus capture: in_valid=1, in_ready=1, flush=1 in the same cycle -> out_valid=0 next cycle.
REQ-038 Async reset mid-stream: assert rst between edges with out_valid=1 and stall_cnt=0xFFFF -> all outputs 0 immediately, without waiting for clk.
